pixel_flag_writer: RTL and testbench

Downstream consumer of the Nios-driven pixel flag output. On a software-raised pixel flag, captures pixel coordinates and colour from the companion output ports, computes a linear framebuffer address, and performs one single-beat write on the framebuffer memory port with wait-request handling. It then reports completion through a four-phase flag/done handshake that software polls.

---
 rtl/pixel_flag_writer_if.sv | 25 ++
 rtl/pixel_flag_writer.sv | 101 ++++++++++
 tb/tb_pixel_flag_writer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_flag_writer_if.sv
// Framebuffer write port: single-beat writes stalled by a wait-request.
// The writer drives the master side, the memory the slave side.
interface pixel_flag_writer_if #(
    parameter int ADDR_W  = 17,
    parameter int COLOR_W = 16
);
    logic [ADDR_W-1:0]  fb_address;
    logic [COLOR_W-1:0] fb_writedata;
    logic               fb_write;
    logic               fb_waitrequest;

    modport master (
        output fb_address,
        output fb_writedata,
        output fb_write,
        input  fb_waitrequest
    );

    modport slave (
        input  fb_address,
        input  fb_writedata,
        input  fb_write,
        output fb_waitrequest
    );
endinterface

// File: rtl/pixel_flag_writer.sv
// Turns a software-raised pixel flag into one framebuffer write, then
// reports completion through a four-phase flag/done handshake.
module pixel_flag_writer #(
    parameter int H_RES   = 320,
    parameter int V_RES   = 240,
    parameter int COLOR_W = 16,
    parameter int ADDR_W  = 17
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pixel_flag,
    input  logic [9:0]         pixel_x,
    input  logic [9:0]         pixel_y,
    input  logic [COLOR_W-1:0] pixel_color,
    pixel_flag_writer_if.master fb,
    output logic               pixel_done,
    output logic               pixel_busy,
    output logic [15:0]        oob_count
);

    localparam int PROD_W = 10 + $clog2(H_RES);

    typedef enum logic [1:0] {IDLE, CALC, WRITE, DONE} state_t;

    state_t             state;
    logic               flag_d;
    logic               rise;
    logic               out_of_range;
    logic [9:0]         x_lat;
    logic [9:0]         y_lat;
    logic [COLOR_W-1:0] color_lat;
    logic [PROD_W-1:0]  lin_addr;

    // flag_d resets high so a flag already up when reset releases is not a request
    assign rise         = pixel_flag & ~flag_d;
    assign out_of_range = (int'(pixel_x) >= H_RES) || (int'(pixel_y) >= V_RES);
    assign lin_addr     = PROD_W'(y_lat) * PROD_W'(H_RES) + PROD_W'(x_lat);

    // Request operands are pure data and need no reset
    always_ff @(posedge clk) begin
        if (state == IDLE && rise) begin
            x_lat     <= pixel_x;
            y_lat     <= pixel_y;
            color_lat <= pixel_color;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            flag_d          <= 1'b1;
            fb.fb_write     <= 1'b0;
            fb.fb_address   <= '0;
            fb.fb_writedata <= '0;
            pixel_done      <= 1'b0;
            pixel_busy      <= 1'b0;
            oob_count       <= '0;
        end else begin
            flag_d <= pixel_flag;
            case (state)
                IDLE: begin
                    if (rise) begin
                        pixel_busy <= 1'b1;
                        if (out_of_range) begin
                            if (oob_count != 16'hFFFF) begin
                                oob_count <= oob_count + 16'd1;
                            end
                            pixel_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    fb.fb_address   <= ADDR_W'(lin_addr);
                    fb.fb_writedata <= color_lat;
                    fb.fb_write     <= 1'b1;
                    state           <= WRITE;
                end
                WRITE: begin
                    // Address and data stay put until the slave takes the beat
                    if (!fb.fb_waitrequest) begin
                        fb.fb_write <= 1'b0;
                        pixel_done  <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (!pixel_flag) begin
                        pixel_done <= 1'b0;
                        pixel_busy <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_flag_writer.sv
// Directed bench for pixel_flag_writer: expected framebuffer writes are
// queued as requests are issued and matched against accepted beats.
module tb_pixel_flag_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pixel_flag = 1'b0;
    logic [9:0]  pixel_x = '0;
    logic [9:0]  pixel_y = '0;
    logic [15:0] pixel_color = '0;
    logic        pixel_done;
    logic        pixel_busy;
    logic [15:0] oob_count;

    int checks = 0;
    int errors = 0;
    int write_cycles = 0;
    int wc0;

    typedef struct packed {
        logic [16:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         popped;
    logic        prev_write = 1'b0;
    logic [16:0] prev_addr = '0;
    logic [15:0] prev_data = '0;

    pixel_flag_writer_if #(.ADDR_W(17), .COLOR_W(16)) fb_bus ();

    pixel_flag_writer #(
        .H_RES(320), .V_RES(240), .COLOR_W(16), .ADDR_W(17)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pixel_flag (pixel_flag),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .pixel_color(pixel_color),
        .fb         (fb_bus.master),
        .pixel_done (pixel_done),
        .pixel_busy (pixel_busy),
        .oob_count  (oob_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input logic lvl, input string tag);
        int n = 0;
        while (pixel_done !== lvl && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(pixel_done), 32'(lvl));
    endtask

    // Memory-side monitor: checks stability while stalled and pops on acceptance
    always @(negedge clk) begin
        if (fb_bus.fb_write) begin
            write_cycles++;
            if (prev_write) begin
                check("addr_stable", 32'(fb_bus.fb_address), 32'(prev_addr));
                check("data_stable", 32'(fb_bus.fb_writedata), 32'(prev_data));
            end
            if (!fb_bus.fb_waitrequest) begin
                check("write_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    popped = exp_q.pop_front();
                    check("wr_addr", 32'(fb_bus.fb_address), 32'(popped.addr));
                    check("wr_data", 32'(fb_bus.fb_writedata), 32'(popped.data));
                end
            end
        end
        prev_write = fb_bus.fb_write;
        prev_addr  = fb_bus.fb_address;
        prev_data  = fb_bus.fb_writedata;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        fb_bus.fb_waitrequest = 1'b0;
        tick();
        tick();
        check("rst_write", 32'(fb_bus.fb_write), 32'd0);
        check("rst_addr", 32'(fb_bus.fb_address), 32'd0);
        check("rst_data", 32'(fb_bus.fb_writedata), 32'd0);
        check("rst_done", 32'(pixel_done), 32'd0);
        check("rst_busy", 32'(pixel_busy), 32'd0);
        check("rst_oob", 32'(oob_count), 32'd0);
        reset = 1'b0;
        tick();
        tick();

        // In-range write, zero wait states
        wc0 = write_cycles;
        pixel_x = 10'd5; pixel_y = 10'd2; pixel_color = 16'hF800;
        exp_q.push_back({17'd645, 16'hF800});
        pixel_flag = 1'b1;
        tick();
        check("t1_busy_n", 32'(pixel_busy), 32'd1);
        check("t1_write_n", 32'(fb_bus.fb_write), 32'd0);
        check("t1_done_n", 32'(pixel_done), 32'd0);
        tick();
        check("t1_write_n1", 32'(fb_bus.fb_write), 32'd1);
        check("t1_addr", 32'(fb_bus.fb_address), 32'd645);
        check("t1_data", 32'(fb_bus.fb_writedata), 32'hF800);
        tick();
        check("t1_write_n2", 32'(fb_bus.fb_write), 32'd0);
        check("t1_done_n2", 32'(pixel_done), 32'd1);
        pixel_flag = 1'b0;
        tick();
        check("t1_done_clr", 32'(pixel_done), 32'd0);
        check("t1_busy_clr", 32'(pixel_busy), 32'd0);
        check("t1_wr_cycles", 32'(write_cycles - wc0), 32'd1);
        tick();

        // Three wait states on the last pixel of the frame
        wc0 = write_cycles;
        fb_bus.fb_waitrequest = 1'b1;
        pixel_x = 10'd319; pixel_y = 10'd239; pixel_color = 16'h1234;
        exp_q.push_back({17'd76799, 16'h1234});
        pixel_flag = 1'b1;
        tick();
        tick();
        check("t2_write_start", 32'(fb_bus.fb_write), 32'd1);
        check("t2_addr", 32'(fb_bus.fb_address), 32'd76799);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_write_held", 32'(fb_bus.fb_write), 32'd1);
            check("t2_done_low", 32'(pixel_done), 32'd0);
        end
        fb_bus.fb_waitrequest = 1'b0;
        tick();
        check("t2_write_end", 32'(fb_bus.fb_write), 32'd0);
        check("t2_done", 32'(pixel_done), 32'd1);
        check("t2_wr_cycles", 32'(write_cycles - wc0), 32'd4);
        pixel_flag = 1'b0;
        tick();
        check("t2_done_clr", 32'(pixel_done), 32'd0);
        tick();

        // Out-of-range requests: column then row
        wc0 = write_cycles;
        pixel_x = 10'd320; pixel_y = 10'd0;
        pixel_flag = 1'b1;
        tick();
        check("t3_done_x", 32'(pixel_done), 32'd1);
        check("t3_oob_x", 32'(oob_count), 32'd1);
        pixel_flag = 1'b0;
        tick();
        check("t3_done_clr_x", 32'(pixel_done), 32'd0);
        tick();
        pixel_x = 10'd0; pixel_y = 10'd240;
        pixel_flag = 1'b1;
        tick();
        check("t3_done_y", 32'(pixel_done), 32'd1);
        check("t3_oob_y", 32'(oob_count), 32'd2);
        pixel_flag = 1'b0;
        tick();
        check("t3_done_clr_y", 32'(pixel_done), 32'd0);
        check("t3_busy_clr_y", 32'(pixel_busy), 32'd0);
        check("t3_no_write", 32'(write_cycles - wc0), 32'd0);
        tick();

        // Flag held high while reset releases
        wc0 = write_cycles;
        pixel_flag = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        check("t4_oob_rst", 32'(oob_count), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_no_done", 32'(pixel_done), 32'd0);
            check("t4_no_busy", 32'(pixel_busy), 32'd0);
        end
        check("t4_no_write", 32'(write_cycles - wc0), 32'd0);
        pixel_flag = 1'b0;
        tick();
        pixel_x = 10'd1; pixel_y = 10'd1; pixel_color = 16'hABCD;
        exp_q.push_back({17'd321, 16'hABCD});
        pixel_flag = 1'b1;
        wait_done(1'b1, "t4_done");
        check("t4_q_empty", 32'(exp_q.size()), 32'd0);
        pixel_flag = 1'b0;
        wait_done(1'b0, "t4_done_clr");
        tick();

        // Flag dropped while the write is stalled
        wc0 = write_cycles;
        fb_bus.fb_waitrequest = 1'b1;
        pixel_x = 10'd10; pixel_y = 10'd3; pixel_color = 16'h07E0;
        exp_q.push_back({17'd970, 16'h07E0});
        pixel_flag = 1'b1;
        tick();
        tick();
        check("t5_write_start", 32'(fb_bus.fb_write), 32'd1);
        pixel_flag = 1'b0;
        tick();
        check("t5_write_kept", 32'(fb_bus.fb_write), 32'd1);
        check("t5_busy_kept", 32'(pixel_busy), 32'd1);
        fb_bus.fb_waitrequest = 1'b0;
        tick();
        check("t5_write_end", 32'(fb_bus.fb_write), 32'd0);
        check("t5_done_pulse", 32'(pixel_done), 32'd1);
        tick();
        check("t5_done_drop", 32'(pixel_done), 32'd0);
        check("t5_idle", 32'(pixel_busy), 32'd0);
        check("t5_wr_cycles", 32'(write_cycles - wc0), 32'd2);
        check("t5_q_empty", 32'(exp_q.size()), 32'd0);
        tick();

        // Reset asserted in the middle of a stalled write
        fb_bus.fb_waitrequest = 1'b1;
        pixel_x = 10'd7; pixel_y = 10'd7; pixel_color = 16'h1111;
        pixel_flag = 1'b1;
        tick();
        tick();
        check("t6_write_start", 32'(fb_bus.fb_write), 32'd1);
        reset = 1'b1;
        #1;
        check("t6_write_async", 32'(fb_bus.fb_write), 32'd0);
        check("t6_addr_rst", 32'(fb_bus.fb_address), 32'd0);
        check("t6_data_rst", 32'(fb_bus.fb_writedata), 32'd0);
        check("t6_busy_rst", 32'(pixel_busy), 32'd0);
        check("t6_done_rst", 32'(pixel_done), 32'd0);
        pixel_flag = 1'b0;
        fb_bus.fb_waitrequest = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("t6_no_done", 32'(pixel_done), 32'd0);
        pixel_x = 10'd100; pixel_y = 10'd200; pixel_color = 16'h5555;
        exp_q.push_back({17'd64100, 16'h5555});
        pixel_flag = 1'b1;
        wait_done(1'b1, "t6_done");
        check("t6_q_empty", 32'(exp_q.size()), 32'd0);
        pixel_flag = 1'b0;
        wait_done(1'b0, "t6_done_clr");
        tick();

        // Counter preloaded just below saturation
        force dut.oob_count = 16'hFFFE;
        #1;
        release dut.oob_count;
        pixel_x = 10'd400; pixel_y = 10'd0;
        pixel_flag = 1'b1;
        tick();
        check("t7_oob_max", 32'(oob_count), 32'hFFFF);
        pixel_flag = 1'b0;
        tick();
        tick();
        pixel_flag = 1'b1;
        tick();
        check("t7_oob_sat", 32'(oob_count), 32'hFFFF);
        check("t7_done", 32'(pixel_done), 32'd1);
        pixel_flag = 1'b0;
        tick();
        check("t7_done_clr", 32'(pixel_done), 32'd0);
        tick();

        check("final_q_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
